// File: rtl/mem_write_checker_pkg.sv
// Shared definitions for the store checker: FSM states, failure codes
// and a small width helper.
package mem_write_checker_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PASS = 2'd1,
        ST_FAIL = 2'd2
    } state_e;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ADDR    = 2'd1;
    localparam logic [1:0] FC_DATA    = 2'd2;
    localparam logic [1:0] FC_TIMEOUT = 2'd3;

    // Width of an entry index; never zero so a single-entry table still
    // has a legal index signal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_write_checker_match.sv
// Combinational lookup of one store against the expected-store table.
// Ordered mode compares only against the lowest unmatched entry (entries
// are consumed in index order, so that is entry match_cnt). Unordered mode
// picks the lowest unmatched entry whose address equals the store address.
module mem_write_checker_match
    import mem_write_checker_pkg::*;
#(
    parameter int                         WIDTH    = 32,
    parameter int                         NUM_CHK  = 4,
    parameter logic [NUM_CHK*WIDTH-1:0]   EXP_ADR  = '0,
    parameter logic [NUM_CHK*WIDTH-1:0]   EXP_DATA = '0,
    parameter bit                         ORDERED  = 1'b1,
    parameter int                         IDX_W    = idx_width(NUM_CHK)
) (
    input  logic [WIDTH-1:0]   adr,
    input  logic [WIDTH-1:0]   data,
    input  logic [NUM_CHK-1:0] matched,
    output logic               hit,
    output logic               data_eq,
    output logic [IDX_W-1:0]   index
);

    logic [NUM_CHK-1:0] adr_eq;
    logic [NUM_CHK-1:0] dat_eq;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHK; gi++) begin : g_entry
            assign adr_eq[gi] = (EXP_ADR[gi*WIDTH +: WIDTH] == adr);
            assign dat_eq[gi] = (EXP_DATA[gi*WIDTH +: WIDTH] == data);
        end

        if (ORDERED) begin : g_ordered
            // Walk downwards so the lowest unmatched entry is the one chosen.
            always_comb begin
                hit     = 1'b0;
                data_eq = 1'b0;
                index   = '0;
                for (int i = NUM_CHK - 1; i >= 0; i--) begin
                    if (!matched[i]) begin
                        hit     = adr_eq[i];
                        data_eq = dat_eq[i];
                        index   = IDX_W'(i);
                    end
                end
            end
        end else begin : g_unordered
            // Lowest unmatched entry with an equal address wins.
            always_comb begin
                hit     = 1'b0;
                data_eq = 1'b0;
                index   = '0;
                for (int i = NUM_CHK - 1; i >= 0; i--) begin
                    if (!matched[i] && adr_eq[i]) begin
                        hit     = 1'b1;
                        data_eq = dat_eq[i];
                        index   = IDX_W'(i);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mem_write_checker.sv
// Watches the store port of a core under test and checks the stores
// against a table of expected (address, data) pairs. Ends sticky in PASS
// once every entry has matched, or in FAIL on a bad store or timeout.
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int                         WIDTH    = 32,
    parameter int                         NUM_CHK  = 4,
    parameter logic [NUM_CHK*WIDTH-1:0]   EXP_ADR  = '0,
    parameter logic [NUM_CHK*WIDTH-1:0]   EXP_DATA = '0,
    parameter logic [WIDTH-1:0]           IGN_ADR  = 96,
    parameter bit                         ORDERED  = 1'b1,
    parameter int                         TIMEOUT  = 10000,
    localparam int                        CNT_W    = $clog2(NUM_CHK + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] DataAdr,
    input  logic [WIDTH-1:0] WriteData,
    output logic             pass,
    output logic             fail,
    output logic             done,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] match_cnt,
    output logic [WIDTH-1:0] fail_adr,
    output logic [WIDTH-1:0] fail_data,
    output logic [31:0]      cycle_cnt
);

    localparam int          IDX_W   = idx_width(NUM_CHK);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_e             state_q,     state_d;
    logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
    logic [NUM_CHK-1:0] matched_q,   matched_d;
    logic [1:0]         fail_code_q, fail_code_d;
    logic [WIDTH-1:0]   fail_adr_q,  fail_adr_d;
    logic [WIDTH-1:0]   fail_data_q, fail_data_d;
    logic [31:0]        cycle_cnt_q, cycle_cnt_d;

    logic             lk_hit;
    logic             lk_data_eq;
    logic [IDX_W-1:0] lk_index;

    mem_write_checker_match #(
        .WIDTH    (WIDTH),
        .NUM_CHK  (NUM_CHK),
        .EXP_ADR  (EXP_ADR),
        .EXP_DATA (EXP_DATA),
        .ORDERED  (ORDERED),
        .IDX_W    (IDX_W)
    ) u_match (
        .adr     (DataAdr),
        .data    (WriteData),
        .matched (matched_q),
        .hit     (lk_hit),
        .data_eq (lk_data_eq),
        .index   (lk_index)
    );

    // Next-state: evaluate the store, then let a timeout fail the run
    // unless this same edge already decided PASS or FAIL.
    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        matched_d   = matched_q;
        fail_code_d = fail_code_q;
        fail_adr_d  = fail_adr_q;
        fail_data_d = fail_data_q;
        cycle_cnt_d = cycle_cnt_q;

        if (state_q == ST_RUN) begin
            if (cycle_cnt_q != 32'hFFFF_FFFF) begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            end

            if (MemWrite && (DataAdr != IGN_ADR)) begin
                if (lk_hit && lk_data_eq) begin
                    for (int i = 0; i < NUM_CHK; i++) begin
                        if (IDX_W'(i) == lk_index) begin
                            matched_d[i] = 1'b1;
                        end
                    end
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                    if (match_cnt_d == CNT_W'(NUM_CHK)) begin
                        state_d = ST_PASS;
                    end
                end else begin
                    state_d     = ST_FAIL;
                    fail_code_d = lk_hit ? FC_DATA : FC_ADDR;
                    fail_adr_d  = DataAdr;
                    fail_data_d = WriteData;
                end
            end

            if ((TIMEOUT != 0) && (cycle_cnt_q == TO_LAST) && (state_d == ST_RUN)) begin
                state_d     = ST_FAIL;
                fail_code_d = FC_TIMEOUT;
                fail_adr_d  = '0;
                fail_data_d = '0;
            end
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            match_cnt_q <= '0;
            matched_q   <= '0;
            fail_code_q <= FC_NONE;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            matched_q   <= matched_d;
            fail_code_q <= fail_code_d;
            fail_adr_q  <= fail_adr_d;
            fail_data_q <= fail_data_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign pass      = (state_q == ST_PASS);
    assign fail      = (state_q == ST_FAIL);
    assign done      = pass | fail;
    assign fail_code = fail_code_q;
    assign match_cnt = match_cnt_q;
    assign fail_adr  = fail_adr_q;
    assign fail_data = fail_data_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker. Four instances cover the
// single-entry ordered case (no timeout), a 50-cycle timeout, and a
// two-entry table in unordered and ordered modes sharing one stimulus.
module tb_mem_write_checker;
    import mem_write_checker_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance A: NUM_CHK=1 ordered, TIMEOUT=0
    logic        rst_a = 1'b1, mw_a = 1'b0;
    logic [31:0] adr_a = '0, dat_a = '0;
    logic        pass_a, fail_a, done_a;
    logic [1:0]  code_a;
    logic [0:0]  cnt_a;
    logic [31:0] fadr_a, fdat_a, cyc_a;

    mem_write_checker #(
        .WIDTH(32), .NUM_CHK(1), .EXP_ADR(32'd100), .EXP_DATA(32'd7),
        .IGN_ADR(32'd96), .ORDERED(1'b1), .TIMEOUT(0)
    ) u_a (
        .clk(clk), .reset(rst_a), .MemWrite(mw_a), .DataAdr(adr_a), .WriteData(dat_a),
        .pass(pass_a), .fail(fail_a), .done(done_a), .fail_code(code_a),
        .match_cnt(cnt_a), .fail_adr(fadr_a), .fail_data(fdat_a), .cycle_cnt(cyc_a)
    );

    // ---------------- instance T: NUM_CHK=1, TIMEOUT=50, no stores
    logic        rst_t = 1'b1, mw_t = 1'b0;
    logic [31:0] adr_t = '0, dat_t = '0;
    logic        pass_t, fail_t, done_t;
    logic [1:0]  code_t;
    logic [0:0]  cnt_t;
    logic [31:0] fadr_t, fdat_t, cyc_t;

    mem_write_checker #(
        .WIDTH(32), .NUM_CHK(1), .EXP_ADR(32'd100), .EXP_DATA(32'd7),
        .IGN_ADR(32'd96), .ORDERED(1'b1), .TIMEOUT(50)
    ) u_t (
        .clk(clk), .reset(rst_t), .MemWrite(mw_t), .DataAdr(adr_t), .WriteData(dat_t),
        .pass(pass_t), .fail(fail_t), .done(done_t), .fail_code(code_t),
        .match_cnt(cnt_t), .fail_adr(fadr_t), .fail_data(fdat_t), .cycle_cnt(cyc_t)
    );

    // ---------------- instances U (unordered) and O (ordered), NUM_CHK=2
    logic        rst_p = 1'b1, mw_p = 1'b0;
    logic [31:0] adr_p = '0, dat_p = '0;
    logic        pass_u, fail_u, done_u, pass_o, fail_o, done_o;
    logic [1:0]  code_u, code_o, cnt_u, cnt_o;
    logic [31:0] fadr_u, fdat_u, cyc_u, fadr_o, fdat_o, cyc_o;

    mem_write_checker #(
        .WIDTH(32), .NUM_CHK(2), .EXP_ADR({32'd104, 32'd100}), .EXP_DATA({32'd9, 32'd7}),
        .IGN_ADR(32'd96), .ORDERED(1'b0), .TIMEOUT(10000)
    ) u_u (
        .clk(clk), .reset(rst_p), .MemWrite(mw_p), .DataAdr(adr_p), .WriteData(dat_p),
        .pass(pass_u), .fail(fail_u), .done(done_u), .fail_code(code_u),
        .match_cnt(cnt_u), .fail_adr(fadr_u), .fail_data(fdat_u), .cycle_cnt(cyc_u)
    );

    mem_write_checker #(
        .WIDTH(32), .NUM_CHK(2), .EXP_ADR({32'd104, 32'd100}), .EXP_DATA({32'd9, 32'd7}),
        .IGN_ADR(32'd96), .ORDERED(1'b1), .TIMEOUT(10000)
    ) u_o (
        .clk(clk), .reset(rst_p), .MemWrite(mw_p), .DataAdr(adr_p), .WriteData(dat_p),
        .pass(pass_o), .fail(fail_o), .done(done_o), .fail_code(code_o),
        .match_cnt(cnt_o), .fail_adr(fadr_o), .fail_data(fdat_o), .cycle_cnt(cyc_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store_a(input logic [31:0] a, input logic [31:0] d);
        mw_a = 1'b1; adr_a = a; dat_a = d;
        tick();
        mw_a = 1'b0;
        $display("A store adr=%0d data=%0d -> pass=%0d fail=%0d code=%0d cnt=%0d",
                 a, d, pass_a, fail_a, code_a, cnt_a);
    endtask

    task automatic store_p(input logic [31:0] a, input logic [31:0] d);
        mw_p = 1'b1; adr_p = a; dat_p = d;
        tick();
        mw_p = 1'b0;
        $display("P store adr=%0d data=%0d -> U pass=%0d code=%0d cnt=%0d | O pass=%0d code=%0d cnt=%0d",
                 a, d, pass_u, code_u, cnt_u, pass_o, code_o, cnt_o);
    endtask

    task automatic reset_a();
        rst_a = 1'b1; tick(); rst_a = 1'b0;
    endtask

    task automatic reset_p();
        rst_p = 1'b1; tick(); rst_p = 1'b0;
    endtask

    initial begin
        // Reset everything; check reset values while reset is still high.
        tick();
        check("rst_a_done",  32'(done_a), 0);
        check("rst_a_code",  32'(code_a), 0);
        check("rst_a_cnt",   32'(cnt_a),  0);
        check("rst_a_cyc",   cyc_a,       0);
        check("rst_u_cnt",   32'(cnt_u),  0);
        check("rst_o_fadr",  fadr_o,      0);

        // ---- timeout: 50 RUN cycles then FAIL code 3, cycle_cnt frozen at 50
        rst_t = 1'b0;
        repeat (49) tick();
        check("to_before_fail", 32'(fail_t), 0);
        check("to_before_cyc",  cyc_t,       49);
        tick();
        $display("T timeout edge -> fail=%0d code=%0d cyc=%0d", fail_t, code_t, cyc_t);
        check("to_fail", 32'(fail_t), 1);
        check("to_code", 32'(code_t), 32'(FC_TIMEOUT));
        check("to_cyc",  cyc_t,       50);
        check("to_fadr", fadr_t,      0);
        repeat (5) tick();
        check("to_cyc_frozen", cyc_t, 50);

        // ---- single entry: ignored store then matching store
        reset_a();
        store_a(32'd96, 32'd5);
        check("ign_cnt",  32'(cnt_a),  0);
        check("ign_done", 32'(done_a), 0);
        store_a(32'd100, 32'd7);
        check("p1_pass", 32'(pass_a), 1);
        check("p1_fail", 32'(fail_a), 0);
        check("p1_code", 32'(code_a), 0);
        check("p1_cnt",  32'(cnt_a),  1);
        check("p1_cyc",  cyc_a,       2);
        store_a(32'd104, 32'd7);
        check("p1_sticky_pass", 32'(pass_a), 1);
        check("p1_sticky_fail", 32'(fail_a), 0);
        check("p1_cyc_frozen",  cyc_a,       2);

        // ---- data mismatch, then a correct store is ignored
        reset_a();
        store_a(32'd100, 32'd8);
        check("dm_fail", 32'(fail_a), 1);
        check("dm_code", 32'(code_a), 32'(FC_DATA));
        check("dm_fadr", fadr_a,      100);
        check("dm_fdat", fdat_a,      8);
        store_a(32'd100, 32'd7);
        check("dm_after_pass", 32'(pass_a), 0);
        check("dm_after_code", 32'(code_a), 32'(FC_DATA));
        check("dm_after_fdat", fdat_a,      8);

        // ---- unexpected address
        reset_a();
        store_a(32'd104, 32'd7);
        check("ua_fail", 32'(fail_a), 1);
        check("ua_code", 32'(code_a), 32'(FC_ADDR));
        check("ua_fadr", fadr_a,      104);

        // ---- TIMEOUT=0: long idle never fails
        reset_a();
        repeat (60) tick();
        check("nto_done", 32'(done_a), 0);
        check("nto_cyc",  cyc_a,       60);

        // ---- two entries, out-of-order stores
        rst_p = 1'b0;
        store_p(32'd104, 32'd9);
        check("oo_o_fail", 32'(fail_o), 1);
        check("oo_o_code", 32'(code_o), 32'(FC_ADDR));
        check("oo_o_fadr", fadr_o,      104);
        check("oo_u_cnt1", 32'(cnt_u),  1);
        store_p(32'd100, 32'd7);
        check("oo_u_pass", 32'(pass_u), 1);
        check("oo_u_cnt",  32'(cnt_u),  2);
        check("oo_o_cnt",  32'(cnt_o),  0);

        // ---- reset after one match with a store pending during reset
        reset_p();
        store_p(32'd100, 32'd7);
        check("rm_o_cnt1", 32'(cnt_o), 1);
        rst_p = 1'b1; mw_p = 1'b1; adr_p = 32'd104; dat_p = 32'd9;
        tick();
        rst_p = 1'b0; mw_p = 1'b0;
        $display("P reset with store pending -> O cnt=%0d done=%0d cyc=%0d", cnt_o, done_o, cyc_o);
        check("rm_o_cnt",  32'(cnt_o),  0);
        check("rm_o_done", 32'(done_o), 0);
        check("rm_o_cyc",  cyc_o,       0);
        check("rm_u_cnt",  32'(cnt_u),  0);
        store_p(32'd100, 32'd7);
        store_p(32'd104, 32'd9);
        check("rm_o_pass", 32'(pass_o), 1);
        check("rm_o_cnt2", 32'(cnt_o),  2);
        check("rm_u_pass", 32'(pass_u), 1);

        // ---- unordered data mismatch on a known address
        reset_p();
        store_p(32'd104, 32'd8);
        check("ud_u_code", 32'(code_u), 32'(FC_DATA));
        check("ud_u_fdat", fdat_u,      8);
        check("ud_o_code", 32'(code_o), 32'(FC_ADDR));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
